// File: rtl/ex_unit_pkg.sv
// ex_unit_pkg: operation codes, write/reset constants, multiplier FSM states and
// the leading-zero helper shared by the execute stage.
package ex_unit_pkg;
    localparam int ALU_OP_W  = 8;
    localparam int ALU_SEL_W = 3;

    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0;

    localparam logic [ALU_OP_W-1:0] OP_NOP   = 8'b0000_0000;
    localparam logic [ALU_OP_W-1:0] OP_AND   = 8'b0010_0100;
    localparam logic [ALU_OP_W-1:0] OP_OR    = 8'b0010_0101;
    localparam logic [ALU_OP_W-1:0] OP_XOR   = 8'b0010_0110;
    localparam logic [ALU_OP_W-1:0] OP_NOR   = 8'b0010_0111;
    localparam logic [ALU_OP_W-1:0] OP_SLL   = 8'b0111_1100;
    localparam logic [ALU_OP_W-1:0] OP_SRL   = 8'b0000_0010;
    localparam logic [ALU_OP_W-1:0] OP_SRA   = 8'b0000_0011;
    localparam logic [ALU_OP_W-1:0] OP_MOVZ  = 8'b0000_1010;
    localparam logic [ALU_OP_W-1:0] OP_MOVN  = 8'b0000_1011;
    localparam logic [ALU_OP_W-1:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [ALU_OP_W-1:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [ALU_OP_W-1:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [ALU_OP_W-1:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [ALU_OP_W-1:0] OP_SLT   = 8'b0010_1010;
    localparam logic [ALU_OP_W-1:0] OP_SLTU  = 8'b0010_1011;
    localparam logic [ALU_OP_W-1:0] OP_ADD   = 8'b0010_0000;
    localparam logic [ALU_OP_W-1:0] OP_ADDU  = 8'b0010_0001;
    localparam logic [ALU_OP_W-1:0] OP_SUB   = 8'b0010_0010;
    localparam logic [ALU_OP_W-1:0] OP_SUBU  = 8'b0010_0011;
    localparam logic [ALU_OP_W-1:0] OP_ADDI  = 8'b0101_0101;
    localparam logic [ALU_OP_W-1:0] OP_ADDIU = 8'b0101_0110;
    localparam logic [ALU_OP_W-1:0] OP_CLZ   = 8'b1011_0000;
    localparam logic [ALU_OP_W-1:0] OP_CLO   = 8'b1011_0001;
    localparam logic [ALU_OP_W-1:0] OP_MULT  = 8'b0001_1000;
    localparam logic [ALU_OP_W-1:0] OP_MULTU = 8'b0001_1001;
    localparam logic [ALU_OP_W-1:0] OP_MUL   = 8'b1010_1001;

    localparam logic [ALU_SEL_W-1:0] SEL_NOP        = 3'b000;
    localparam logic [ALU_SEL_W-1:0] SEL_LOGIC      = 3'b001;
    localparam logic [ALU_SEL_W-1:0] SEL_SHIFT      = 3'b010;
    localparam logic [ALU_SEL_W-1:0] SEL_MOVE       = 3'b011;
    localparam logic [ALU_SEL_W-1:0] SEL_ARITHMETIC = 3'b100;
    localparam logic [ALU_SEL_W-1:0] SEL_MUL        = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    // Highest set bit wins because the loop runs upward.
    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++)
            if (v[i]) n = 6'(31 - i);
        return n;
    endfunction
endpackage

// File: rtl/ex_unit_mul_iter.sv
// mul_iter: iterative unsigned 32x32 shift-add multiplier retiring BITS_PER_CYCLE
// multiplier bits per cycle; last is high during the cycle whose edge finishes.
module mul_iter
    import ex_unit_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        last,
    output logic [63:0] product
);
    localparam int         N        = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] LAST_CNT = 6'(N - 1);

    logic [63:0] mcand, acc, partial;
    logic [31:0] mplier;
    logic [5:0]  cnt;
    logic        run;

    always_comb begin
        partial = 64'd0;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            partial = partial + (mplier[i] ? (mcand << i) : 64'd0);
    end

    assign last    = run && cnt == LAST_CNT;
    assign product = acc;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            run    <= 1'b0;
            cnt    <= 6'd0;
            acc    <= 64'd0;
            mcand  <= 64'd0;
            mplier <= 32'd0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= 6'd0;
            acc    <= 64'd0;
            mcand  <= {32'd0, a};
            mplier <= b;
        end else if (run) begin
            acc    <= acc + partial;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
            cnt    <= cnt + 6'd1;
            if (last) run <= 1'b0;
        end
    end
endmodule

// File: rtl/ex_unit.sv
// ex_unit: execute stage -- single-cycle ALU, HI/LO ownership, and a stalling
// iterative multiplier for MULT/MULTU/MUL.
module ex_unit
    import ex_unit_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ALU_OP_W-1:0]  aluop_i,
    input  logic [ALU_SEL_W-1:0] alusel_i,
    input  logic [31:0]          reg1_i,
    input  logic [31:0]          reg2_i,
    input  logic [4:0]           wd_i,
    input  logic                 wreg_i,
    output logic [4:0]           wd_o,
    output logic                 wreg_o,
    output logic [31:0]          wdata_o,
    output logic                 stallreq_o,
    output logic [31:0]          hi_o,
    output logic [31:0]          lo_o
);
    mul_state_t  state, state_next;
    logic [31:0] hi, lo, hi_d, lo_d;
    logic        hi_we, lo_we, sign_neg, mul_start, mul_last;
    logic        is_mul, neg1, neg2, ov_add, ov_sub;
    logic [31:0] sum, diff, sra_res, mag1, mag2;
    logic [31:0] logic_res, shift_res, arith_res, move_res, result;
    logic [63:0] acc, prod;

    assign is_mul = aluop_i == OP_MULT || aluop_i == OP_MULTU || aluop_i == OP_MUL;
    assign neg1   = reg1_i[31] && aluop_i != OP_MULTU;
    assign neg2   = reg2_i[31] && aluop_i != OP_MULTU;
    assign mag1   = neg1 ? -reg1_i : reg1_i;
    assign mag2   = neg2 ? -reg2_i : reg2_i;
    assign prod   = sign_neg ? -acc : acc;

    assign sum     = reg1_i + reg2_i;
    assign diff    = reg1_i - reg2_i;
    assign ov_add  = reg1_i[31] == reg2_i[31] && sum[31] != reg1_i[31];
    assign ov_sub  = reg1_i[31] != reg2_i[31] && diff[31] != reg1_i[31];
    assign sra_res = $signed(reg2_i) >>> reg1_i[4:0];

    assign hi_o = hi;
    assign lo_o = lo;

    mul_iter #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (mag1),
        .b      (mag2),
        .last   (mul_last),
        .product(acc)
    );

    always_comb begin
        logic_res = aluop_i == OP_OR  ? reg1_i | reg2_i :
                    aluop_i == OP_AND ? reg1_i & reg2_i :
                    aluop_i == OP_XOR ? reg1_i ^ reg2_i :
                    aluop_i == OP_NOR ? ~(reg1_i | reg2_i) : ZERO_WORD;
        shift_res = aluop_i == OP_SLL ? reg2_i << reg1_i[4:0] :
                    aluop_i == OP_SRL ? reg2_i >> reg1_i[4:0] :
                    aluop_i == OP_SRA ? sra_res : ZERO_WORD;
        arith_res = (aluop_i == OP_ADD || aluop_i == OP_ADDU ||
                     aluop_i == OP_ADDI || aluop_i == OP_ADDIU) ? sum :
                    (aluop_i == OP_SUB || aluop_i == OP_SUBU) ? diff :
                    aluop_i == OP_SLT  ? {31'd0, $signed(reg1_i) < $signed(reg2_i)} :
                    aluop_i == OP_SLTU ? {31'd0, reg1_i < reg2_i} :
                    aluop_i == OP_CLZ  ? {26'd0, clz32(reg1_i)} :
                    aluop_i == OP_CLO  ? {26'd0, clz32(~reg1_i)} : ZERO_WORD;
        move_res  = aluop_i == OP_MFHI ? hi :
                    aluop_i == OP_MFLO ? lo :
                    (aluop_i == OP_MOVN || aluop_i == OP_MOVZ) ? reg1_i : ZERO_WORD;
        result    = alusel_i == SEL_LOGIC      ? logic_res :
                    alusel_i == SEL_SHIFT      ? shift_res :
                    alusel_i == SEL_ARITHMETIC ? arith_res :
                    alusel_i == SEL_MOVE       ? move_res  :
                    alusel_i == SEL_MUL        ? prod[31:0] : ZERO_WORD;
    end

    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        stallreq_o = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        hi_d       = prod[63:32];
        lo_d       = prod[31:0];
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = result;
        case (state)
            ST_IDLE: if (is_mul) begin
                mul_start  = 1'b1;
                stallreq_o = 1'b1;
                state_next = ST_BUSY;
            end
            ST_BUSY: begin
                stallreq_o = 1'b1;
                if (mul_last) state_next = ST_DONE;
            end
            ST_DONE: begin
                hi_we      = aluop_i != OP_MUL;
                lo_we      = aluop_i != OP_MUL;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Only MUL in its DONE cycle writes a GPR; MULT/MULTU never do.
        if (is_mul && (state != ST_DONE || aluop_i != OP_MUL)) wreg_o = WRITE_DISABLE;
        if (((aluop_i == OP_ADD || aluop_i == OP_ADDI) && ov_add) ||
            (aluop_i == OP_SUB && ov_sub)) wreg_o = WRITE_DISABLE;
        if (aluop_i == OP_MTHI) begin
            hi_we  = 1'b1;
            hi_d   = reg1_i;
            wreg_o = WRITE_DISABLE;
        end
        if (aluop_i == OP_MTLO) begin
            lo_we  = 1'b1;
            lo_d   = reg1_i;
            wreg_o = WRITE_DISABLE;
        end
        if (rst == RST_ENABLE) begin
            wd_o       = 5'd0;
            wreg_o     = WRITE_DISABLE;
            wdata_o    = ZERO_WORD;
            stallreq_o = 1'b0;
            mul_start  = 1'b0;
            hi_we      = 1'b0;
            lo_we      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state    <= ST_IDLE;
            sign_neg <= 1'b0;
            hi       <= ZERO_WORD;
            lo       <= ZERO_WORD;
        end else begin
            state <= state_next;
            if (mul_start) sign_neg <= neg1 ^ neg2;
            if (hi_we) hi <= hi_d;
            if (lo_we) lo <= lo_d;
        end
    end
endmodule

// File: tb/tb_ex_unit.sv
// tb_ex_unit: directed vectors with a cycle-tagged scoreboard checked by a
// negedge monitor; two instances cover BITS_PER_CYCLE of 1 and 4.
module tb_ex_unit;
    import ex_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop, aluop4;
    logic [2:0]  alusel, alusel4;
    logic [31:0] reg1, reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [4:0]  wd1, wd4;
    logic        wreg1, wreg4, stall1, stall4;
    logic [31:0] wdata1, wdata4, hi1, hi4, lo1, lo4;

    ex_unit #(.BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel), .reg1_i(reg1), .reg2_i(reg2),
        .wd_i(wd), .wreg_i(wreg), .wd_o(wd1), .wreg_o(wreg1), .wdata_o(wdata1),
        .stallreq_o(stall1), .hi_o(hi1), .lo_o(lo1)
    );

    ex_unit #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .aluop_i(aluop4), .alusel_i(alusel4), .reg1_i(reg1), .reg2_i(reg2),
        .wd_i(wd), .wreg_i(wreg), .wd_o(wd4), .wreg_o(wreg4), .wdata_o(wdata4),
        .stallreq_o(stall4), .hi_o(hi4), .lo_o(lo4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {K_WDATA, K_WREG, K_WD, K_STALL, K_HI, K_LO} kind_t;
    typedef struct {
        int          cyc;
        int          dut;
        kind_t       kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic expect_at(input int c, input int d, input kind_t k, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc = c; e.dut = d; e.kind = k; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic chk(input kind_t k, input logic [31:0] v, input string n);
        expect_at(cyc, 1, k, v, n);
    endtask

    function automatic logic [31:0] sample(input int d, input kind_t k);
        case (k)
            K_WDATA: return d == 4 ? wdata4 : wdata1;
            K_WREG:  return {31'd0, d == 4 ? wreg4 : wreg1};
            K_WD:    return {27'd0, d == 4 ? wd4 : wd1};
            K_STALL: return {31'd0, d == 4 ? stall4 : stall1};
            K_HI:    return d == 4 ? hi4 : hi1;
            default: return d == 4 ? lo4 : lo1;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = sample(e.dut, e.kind);
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
                fails++;
                $display("FAIL %s (dut%0d cycle %0d, seen at %0d): got %h, expected %h",
                         e.name, e.dut, e.cyc, cyc, act, e.val);
            end
        end
    end

    // Presents one operation to the selected instance; the other sees a NOP.
    task automatic issue(input int t, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] d, input logic w);
        @(posedge clk);
        #1;
        aluop   = t == 4 ? OP_NOP  : op;
        alusel  = t == 4 ? SEL_NOP : sel;
        aluop4  = t == 4 ? op  : OP_NOP;
        alusel4 = t == 4 ? sel : SEL_NOP;
        reg1 = a; reg2 = b; wd = d; wreg = w;
    endtask

    task automatic mul_stall(input int t, input int n, input logic w, input string nm);
        for (int i = 0; i < n; i++) expect_at(cyc + i, t, K_STALL, 32'd1, {nm, "_stall"});
        expect_at(cyc + n, t, K_STALL, 32'd0, {nm, "_done_stall"});
        expect_at(cyc + n, t, K_WREG, {31'd0, w}, {nm, "_done_wreg"});
    endtask

    initial begin
        rst = 1'b1;
        aluop = OP_OR; alusel = SEL_LOGIC; reg1 = 32'h0000F0F0; reg2 = 32'h00FF0000;
        wd = 5'd5; wreg = 1'b1; aluop4 = OP_NOP; alusel4 = SEL_NOP;
        @(posedge clk);
        #1;
        chk(K_WDATA, 32'd0, "rst_wdata"); chk(K_WREG, 32'd0, "rst_wreg");
        chk(K_WD, 32'd0, "rst_wd");       chk(K_STALL, 32'd0, "rst_stall");
        chk(K_HI, 32'd0, "rst_hi");       chk(K_LO, 32'd0, "rst_lo");

        issue(1, OP_OR, SEL_LOGIC, 32'h0000F0F0, 32'h00FF0000, 5'd5, 1'b1);
        rst = 1'b0;
        chk(K_WDATA, 32'h00FFF0F0, "or_wdata"); chk(K_WD, 32'd5, "or_wd");
        chk(K_WREG, 32'd1, "or_wreg");          chk(K_STALL, 32'd0, "or_stall");
        issue(1, OP_AND, SEL_LOGIC, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd2, 1'b1);
        chk(K_WDATA, 32'h00F000F0, "and");
        issue(1, OP_XOR, SEL_LOGIC, 32'hA5A5A5A5, 32'hFFFF0000, 5'd2, 1'b1);
        chk(K_WDATA, 32'h5A5AA5A5, "xor");
        issue(1, OP_NOR, SEL_LOGIC, 32'h0, 32'h0, 5'd2, 1'b1);
        chk(K_WDATA, 32'hFFFFFFFF, "nor");
        issue(1, 8'hFF, SEL_LOGIC, 32'h1234, 32'h5678, 5'd2, 1'b1);
        chk(K_WDATA, 32'd0, "unknown_op");
        issue(1, OP_OR, SEL_NOP, 32'h1234, 32'h5678, 5'd2, 1'b1);
        chk(K_WDATA, 32'd0, "sel_nop");

        issue(1, OP_SLL, SEL_SHIFT, 32'd31, 32'd1, 5'd3, 1'b1);
        chk(K_WDATA, 32'h80000000, "sll");
        issue(1, OP_SRL, SEL_SHIFT, 32'h24, 32'h80000000, 5'd3, 1'b1);
        chk(K_WDATA, 32'h08000000, "srl_amount_5bits");
        issue(1, OP_SRA, SEL_SHIFT, 32'd4, 32'h80000000, 5'd3, 1'b1);
        chk(K_WDATA, 32'hF8000000, "sra");

        issue(1, OP_ADD, SEL_ARITHMETIC, 32'h7FFFFFFF, 32'd1, 5'd4, 1'b1);
        chk(K_WREG, 32'd0, "add_overflow_wreg");
        issue(1, OP_ADDU, SEL_ARITHMETIC, 32'h7FFFFFFF, 32'd1, 5'd4, 1'b1);
        chk(K_WDATA, 32'h80000000, "addu_wdata"); chk(K_WREG, 32'd1, "addu_wreg");
        issue(1, OP_ADDI, SEL_ARITHMETIC, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1);
        chk(K_WDATA, 32'd0, "addi_wdata"); chk(K_WREG, 32'd1, "addi_no_overflow");
        issue(1, OP_SUB, SEL_ARITHMETIC, 32'h80000000, 32'd1, 5'd4, 1'b1);
        chk(K_WREG, 32'd0, "sub_overflow_wreg");
        issue(1, OP_SUBU, SEL_ARITHMETIC, 32'h80000000, 32'd1, 5'd4, 1'b1);
        chk(K_WDATA, 32'h7FFFFFFF, "subu_wdata"); chk(K_WREG, 32'd1, "subu_wreg");
        issue(1, OP_SLT, SEL_ARITHMETIC, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1);
        chk(K_WDATA, 32'd1, "slt");
        issue(1, OP_SLTU, SEL_ARITHMETIC, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1);
        chk(K_WDATA, 32'd0, "sltu");
        issue(1, OP_CLZ, SEL_ARITHMETIC, 32'h00010000, 32'd0, 5'd4, 1'b1);
        chk(K_WDATA, 32'd15, "clz");
        issue(1, OP_CLZ, SEL_ARITHMETIC, 32'h0, 32'd0, 5'd4, 1'b1);
        chk(K_WDATA, 32'd32, "clz_zero");
        issue(1, OP_CLO, SEL_ARITHMETIC, 32'hF0000000, 32'd0, 5'd4, 1'b1);
        chk(K_WDATA, 32'd4, "clo");

        issue(1, OP_MOVN, SEL_MOVE, 32'hDEADBEEF, 32'd1, 5'd3, 1'b1);
        chk(K_WDATA, 32'hDEADBEEF, "movn_wdata"); chk(K_WREG, 32'd1, "movn_wreg");
        issue(1, OP_MTHI, SEL_NOP, 32'h12345678, 32'd0, 5'd0, 1'b1);
        chk(K_WREG, 32'd0, "mthi_wreg"); chk(K_HI, 32'd0, "mthi_old_hi");
        issue(1, OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd6, 1'b1);
        chk(K_WDATA, 32'h12345678, "mfhi_new"); chk(K_WREG, 32'd1, "mfhi_wreg");
        issue(1, OP_MTLO, SEL_NOP, 32'h9ABCDEF0, 32'd0, 5'd0, 1'b1);
        chk(K_WREG, 32'd0, "mtlo_wreg");
        issue(1, OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd6, 1'b1);
        chk(K_WDATA, 32'h9ABCDEF0, "mflo_new");

        issue(1, OP_MULT, SEL_NOP, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0);
        mul_stall(1, 33, 1'b0, "mult");
        expect_at(cyc + 33, 1, K_HI, 32'h12345678, "mult_hi_held");
        expect_at(cyc + 34, 1, K_HI, 32'hFFFFFFFF, "mult_hi");
        expect_at(cyc + 34, 1, K_LO, 32'hFFFFFFFF, "mult_lo");
        repeat (33) @(posedge clk);
        issue(1, OP_MULTU, SEL_NOP, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0);
        mul_stall(1, 33, 1'b0, "multu");
        expect_at(cyc + 34, 1, K_HI, 32'hFFFFFFFE, "multu_hi");
        expect_at(cyc + 34, 1, K_LO, 32'h00000001, "multu_lo");
        repeat (33) @(posedge clk);
        issue(1, OP_MUL, SEL_MUL, 32'h80000000, 32'h80000000, 5'd7, 1'b1);
        mul_stall(1, 33, 1'b1, "mul");
        expect_at(cyc + 33, 1, K_WDATA, 32'd0, "mul_wdata");
        expect_at(cyc + 33, 1, K_WD, 32'd7, "mul_wd");
        expect_at(cyc + 34, 1, K_HI, 32'hFFFFFFFE, "mul_hi_unchanged");
        expect_at(cyc + 34, 1, K_LO, 32'h00000001, "mul_lo_unchanged");
        repeat (33) @(posedge clk);

        issue(4, OP_MUL, SEL_MUL, 32'h80000000, 32'h80000000, 5'd7, 1'b1);
        mul_stall(4, 9, 1'b1, "mul4");
        expect_at(cyc + 9, 4, K_WDATA, 32'd0, "mul4_wdata");
        expect_at(cyc + 10, 4, K_HI, 32'd0, "mul4_hi_unchanged");
        repeat (9) @(posedge clk);
        issue(4, OP_MUL, SEL_MUL, 32'hFFFFFFFD, 32'd5, 5'd8, 1'b1);
        mul_stall(4, 9, 1'b1, "mul4_neg");
        expect_at(cyc + 9, 4, K_WDATA, 32'hFFFFFFF1, "mul4_neg_wdata");
        repeat (9) @(posedge clk);
        issue(4, OP_MULT, SEL_NOP, 32'hFFFFFFFD, 32'd5, 5'd0, 1'b0);
        mul_stall(4, 9, 1'b0, "mult4");
        expect_at(cyc + 10, 4, K_HI, 32'hFFFFFFFF, "mult4_hi");
        expect_at(cyc + 10, 4, K_LO, 32'hFFFFFFF1, "mult4_lo");
        repeat (9) @(posedge clk);

        issue(1, OP_MULT, SEL_NOP, 32'd7, 32'd9, 5'd0, 1'b0);
        chk(K_STALL, 32'd1, "rstmul_start_stall");
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        chk(K_STALL, 32'd0, "rstmul_in_reset_stall");
        issue(1, OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        rst = 1'b0;
        chk(K_STALL, 32'd0, "rstmul_after_stall");
        chk(K_HI, 32'd0, "rstmul_hi"); chk(K_LO, 32'd0, "rstmul_lo");
        expect_at(cyc, 4, K_HI, 32'd0, "rstmul_hi4");
        issue(1, OP_MULT, SEL_NOP, 32'd3, 32'd5, 5'd0, 1'b0);
        mul_stall(1, 33, 1'b0, "mult35");
        expect_at(cyc + 34, 1, K_HI, 32'd0, "mult35_hi");
        expect_at(cyc + 34, 1, K_LO, 32'd15, "mult35_lo");
        repeat (33) @(posedge clk);

        issue(1, OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (5) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000");
        $fatal(1, "timeout");
    end
endmodule
